// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and widths for the cache / memory arbiter, the caches and
// the cacheline adaptor.
package cache_arb_types;

  localparam int unsigned CACHE_LINE_WIDTH  = 256;
  localparam int unsigned CACHE_ADDR_WIDTH  = 32;
  localparam int unsigned CACHE_OFFSET_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    I_MEM,
    D_RD,
    D_WR,
    RESP
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } requester_t;

endpackage

// File: rtl/cache_mem_arbiter_watchdog.sv
// Response watchdog: counts cycles spent waiting on memory and flags expiry
// on the last allowed cycle. TIMEOUT_CYCLES == 0 disables it.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count only while a memory transaction is outstanding; restart otherwise.
  always_ff @(posedge clk) begin
    if (!rst || start || clear || !run) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && run && (count == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the icache and dcache onto a single line-wide memory port,
// one transaction at a time, and returns the response to the owner.
import cache_arb_types::*;

module cache_mem_arbiter #(
  parameter int unsigned LINE_WIDTH     = CACHE_LINE_WIDTH,
  parameter int unsigned ADDR_WIDTH     = CACHE_ADDR_WIDTH,
  parameter int unsigned OFFSET_BITS    = CACHE_OFFSET_BITS,
  parameter int unsigned ROUND_ROBIN    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  arb_state_t state;
  requester_t last_grant;

  logic d_req;
  logic any_req;
  logic grant_d;
  logic in_mem;
  logic expire;

  assign d_req   = d_read | d_write;
  assign any_req = i_read | d_req;
  // dcache wins when alone, under fixed priority, or when icache won last.
  assign grant_d = d_req && (!i_read || (ROUND_ROBIN == 0) || (last_grant == ICACHE));
  assign in_mem  = (state == I_MEM) || (state == D_RD) || (state == D_WR);

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  ((state == IDLE) && any_req),
    .run    (in_mem),
    .clear  (mem_resp),
    .expire (expire)
  );

  // Arbitration and transaction sequencing with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= ICACHE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      i_resp      <= 1'b0;
      d_resp      <= 1'b0;
      err         <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_wdata <= d_wdata;
            if (grant_d) begin
              last_grant  <= DCACHE;
              mem_address <= d_address & LINE_MASK;
              if (d_write) begin
                state     <= D_WR;
                mem_write <= 1'b1;
              end else begin
                state    <= D_RD;
                mem_read <= 1'b1;
              end
            end else begin
              last_grant  <= ICACHE;
              mem_address <= i_address & LINE_MASK;
              state       <= I_MEM;
              mem_read    <= 1'b1;
            end
          end
        end
        I_MEM, D_RD, D_WR: begin
          // A response in the expiry cycle still completes normally.
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RESP;
            if (state == I_MEM) begin
              i_rdata <= mem_rdata;
              i_resp  <= 1'b1;
            end else begin
              d_resp <= 1'b1;
              if (state == D_RD) begin
                d_rdata <= mem_rdata;
              end
            end
          end else if (expire) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err       <= 1'b1;
            state     <= IDLE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a round-robin instance with a short
// watchdog and a fixed-priority instance sharing the same stimulus.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read, d_read, d_write, mem_resp;
  logic [31:0]  i_address, d_address;
  logic [255:0] d_wdata, mem_rdata;

  logic [255:0] i_rdata, d_rdata, mem_wdata;
  logic         i_resp, d_resp, mem_read, mem_write, err;
  logic [31:0]  mem_address;

  logic [255:0] i_rdata_b, d_rdata_b, mem_wdata_b;
  logic         i_resp_b, d_resp_b, mem_read_b, mem_write_b, err_b;
  logic [31:0]  mem_address_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_i, exp_d;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ROUND_ROBIN   (1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err)
  );

  cache_mem_arbiter #(
    .ROUND_ROBIN   (0),
    .TIMEOUT_CYCLES(1024)
  ) dut_fixed (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata_b), .i_resp(i_resp_b),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata_b), .d_resp(d_resp_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_address(mem_address_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err_b)
  );

  typedef struct {
    logic         ir, dr, dw;
    logic [31:0]  ia, da, ea;
    logic [255:0] wd, rd;
    int           lat;
    logic         er, ew, own_d;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0, 32'h0000_0060,
                '0, {32{8'hA5}}, 9, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h1000_003F, 32'h1000_0020,
                '0, {32{8'h5A}}, 2, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h8000_0040, 32'h8000_0040,
                {64{4'h1}}, {32{8'hEE}}, 3, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h8000_0044, 32'h8000_0040,
                {64{4'h3}}, {32{8'hDD}}, 1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFE0,
                '0, {32{8'hC3}}, 0, 1'b1, 1'b0, 1'b0};
    // Response lands on the watchdog's last cycle: must complete, no err.
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0000_1220,
                '0, {32{8'h77}}, 15, 1'b1, 1'b0, 1'b0};

    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    step(); step();
    chk("reset mem_read", mem_read, 0);
    chk("reset mem_write", mem_write, 0);
    chk("reset mem_address", mem_address, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset i_rdata", i_rdata, 0);
    chk("reset d_rdata", d_rdata, 0);
    chk("reset resp", {i_resp, d_resp}, 0);
    chk("reset err", err, 0);
    exp_i = '0; exp_d = '0;
    rst = 1'b1;
    step();

    // Ties: both instances give the first tie to the dcache.
    i_read = 1; d_read = 1; i_address = 32'h100; d_address = 32'h200;
    step();
    chk("tie1 rr addr", mem_address, 32'h200);
    chk("tie1 fixed addr", mem_address_b, 32'h200);
    chk("tie1 strobe", {mem_read, mem_write}, 2'b10);
    mem_resp = 1; mem_rdata = {16{16'h1357}};
    step();
    mem_resp = 0;
    chk("tie1 d_resp", d_resp, 1);
    chk("tie1 i_resp", i_resp, 0);
    chk("tie1 d_rdata", d_rdata, {16{16'h1357}});
    chk("tie1 fixed d_resp", d_resp_b, 1);
    exp_d = {16{16'h1357}};
    d_read = 0;
    step();
    chk("tie1 no resp after pulse", {i_resp, d_resp}, 0);
    chk("no grant in RESP", mem_read, 0);
    d_read = 1;
    step();
    chk("tie2 rr addr", mem_address, 32'h100);
    chk("tie2 fixed addr", mem_address_b, 32'h200);
    mem_resp = 1; mem_rdata = {16{16'h2468}};
    step();
    mem_resp = 0;
    chk("tie2 i_resp", i_resp, 1);
    chk("tie2 d_resp", d_resp, 0);
    chk("tie2 i_rdata", i_rdata, {16{16'h2468}});
    chk("tie2 d_rdata held", d_rdata, exp_d);
    chk("tie2 fixed d_resp", d_resp_b, 1);
    chk("tie2 fixed i_resp", i_resp_b, 0);
    exp_i = {16{16'h2468}};
    i_read = 0; d_read = 0;
    step();

    // Single transactions from the vector table.
    for (int unsigned k = 0; k < 6; k++) begin
      i_read = vecs[k].ir; d_read = vecs[k].dr; d_write = vecs[k].dw;
      i_address = vecs[k].ia; d_address = vecs[k].da; d_wdata = vecs[k].wd;
      step();
      chk($sformatf("v%0d mem_read", k), mem_read, vecs[k].er);
      chk($sformatf("v%0d mem_write", k), mem_write, vecs[k].ew);
      chk($sformatf("v%0d mem_address", k), mem_address, vecs[k].ea);
      d_wdata = {64{4'h2}}; d_address = 32'hDEAD_BEEF; i_address = 32'hDEAD_BEEF;
      for (int n = 0; n < vecs[k].lat; n++) step();
      chk($sformatf("v%0d strobe held", k), {mem_read, mem_write}, {vecs[k].er, vecs[k].ew});
      chk($sformatf("v%0d addr held", k), mem_address, vecs[k].ea);
      if (vecs[k].ew) chk($sformatf("v%0d mem_wdata latched", k), mem_wdata, vecs[k].wd);
      mem_resp = 1; mem_rdata = vecs[k].rd;
      step();
      mem_resp = 0; mem_rdata = '1;
      if (!vecs[k].ew) begin
        if (vecs[k].own_d) exp_d = vecs[k].rd;
        else exp_i = vecs[k].rd;
      end
      chk($sformatf("v%0d strobes off", k), {mem_read, mem_write}, 2'b00);
      chk($sformatf("v%0d i_resp", k), i_resp, !vecs[k].own_d);
      chk($sformatf("v%0d d_resp", k), d_resp, vecs[k].own_d);
      chk($sformatf("v%0d i_rdata", k), i_rdata, exp_i);
      chk($sformatf("v%0d d_rdata", k), d_rdata, exp_d);
      chk($sformatf("v%0d err", k), err, 0);
      i_read = 0; d_read = 0; d_write = 0;
      step();
      chk($sformatf("v%0d resp single cycle", k), {i_resp, d_resp}, 0);
    end

    // Watchdog: 16 cycles in I_MEM with no response.
    i_read = 1; i_address = 32'h300;
    step();
    chk("to strobe start", mem_read, 1);
    for (int n = 0; n < 15; n++) step();
    chk("to strobe last cycle", mem_read, 1);
    chk("to err not yet", err, 0);
    step();
    chk("to strobe dropped", mem_read, 0);
    chk("to err set", err, 1);
    chk("to no i_resp", i_resp, 0);
    i_read = 0;
    step();
    chk("to no resp later", {i_resp, d_resp}, 0);
    mem_resp = 1; mem_rdata = {32{8'h99}};
    step();
    mem_resp = 0;
    chk("late resp err sticky", err, 1);
    chk("late resp no i_resp", i_resp, 0);
    chk("late resp i_rdata held", i_rdata, exp_i);
    chk("late resp no strobe", mem_read, 0);
    step();
    chk("err still sticky", err, 1);

    // Reset in the middle of a dcache read.
    d_read = 1; d_address = 32'h400;
    step();
    chk("rst pre mem_read", mem_read, 1);
    step(); step();
    rst = 0; d_read = 0;
    step();
    chk("rst mid mem_read", mem_read, 0);
    chk("rst mid mem_address", mem_address, 0);
    chk("rst mid err", err, 0);
    chk("rst mid d_resp", d_resp, 0);
    chk("rst mid rdata", {i_rdata, d_rdata}, 0);
    rst = 1;
    step();
    chk("rst after no d_resp", d_resp, 0);
    exp_i = '0; exp_d = '0;
    i_read = 1; i_address = 32'h564;
    step();
    chk("post rst mem_read", mem_read, 1);
    chk("post rst addr", mem_address, 32'h560);
    step();
    mem_resp = 1; mem_rdata = {32{8'h3C}};
    step();
    mem_resp = 0;
    chk("post rst i_resp", i_resp, 1);
    chk("post rst i_rdata", i_rdata, {32{8'h3C}});
    chk("post rst d_resp", d_resp, 0);
    i_read = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single burst-line physical memory port (ParamMemory-style, 256-bit lines via the cacheline adaptor) between the instruction cache and the data cache of the RISC-V processor.
- Arbitrates requests and latches the winner's address and write data.
- Sequences exactly one line transaction at a time and routes the memory response back to the owning cache.
- Includes a response watchdog so a hung memory is flagged instead of deadlocking the core.

Parameters:
- LINE_WIDTH, 256, cache line / memory data width in bits
- ADDR_WIDTH, 32, byte address width
- OFFSET_BITS, 5, line offset bits; forced to zero on mem_address
- ROUND_ROBIN, 1, 1 = alternate on tie; 0 = fixed data-cache priority
- TIMEOUT_CYCLES, 1024, max cycles waiting for mem_resp; 0 disables the watchdog

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-low reset (rst==0 resets)
- i_read  in  1  icache line read request, level, held until i_resp
- i_address  in  ADDR_WIDTH  icache line address
- i_rdata  out  LINE_WIDTH  icache read data
- i_resp  out  1  icache completion pulse
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line writeback request, held until d_resp
- d_address  in  ADDR_WIDTH  dcache line address
- d_wdata  in  LINE_WIDTH  dcache writeback data
- d_rdata  out  LINE_WIDTH  dcache read data
- d_resp  out  1  dcache completion pulse
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_WIDTH  line-aligned memory address
- mem_wdata  out  LINE_WIDTH  memory write data
- mem_rdata  in  LINE_WIDTH  memory read data
- mem_resp  in  1  memory completion, one-cycle pulse
- err  out  1  sticky watchdog timeout flag

Behaviour:
- Reset values:
  - state = IDLE; last_grant = ICACHE.
  - mem_read, mem_write, i_resp, d_resp, err = 0.
  - mem_address, mem_wdata, i_rdata, d_rdata = 0.
  - Watchdog count = 0.
- States: IDLE, I_MEM, D_RD, D_WR, RESP.
- IDLE:
  - Samples requests each cycle.
  - A dcache request is d_read|d_write. If d_read and d_write are both high, the request is treated as a write.
  - Only one cache requesting: that cache is granted.
  - Both requesting with ROUND_ROBIN=1: grant the cache that is not last_grant. With ROUND_ROBIN=0: grant the dcache.
  - On grant: register address (low OFFSET_BITS zeroed) and d_wdata, update last_grant, then go to I_MEM, D_RD or D_WR.
  - No request: stay in IDLE; all strobes 0.
- Latency:
  - A request sampled in IDLE at cycle t drives mem_read or mem_write from cycle t+1.
  - The strobe holds until mem_resp.
  - mem_address and mem_wdata come from the latched copies; later changes on d_wdata or the address inputs are ignored.
- In I_MEM, D_RD or D_WR, when mem_resp arrives at cycle u:
  - Deassert the strobe at u+1.
  - Capture mem_rdata into the owner's rdata register (reads only).
  - Go to RESP.
- RESP, cycle u+1:
  - Pulse the owner's resp for exactly one cycle; the other cache's resp stays 0.
  - Go to IDLE at u+2.
- Requester rules:
  - A requester must drop its request by cycle u+2.
  - The earliest next grant is sampled at u+2; there is no back-to-back grant in RESP.
- i_rdata and d_rdata hold their last captured value until the next read response for that cache.
- Watchdog (TIMEOUT_CYCLES != 0):
  - The count increments every cycle in a MEM state and clears on leaving it.
  - When count == TIMEOUT_CYCLES-1 and no mem_resp has arrived: set err, drop the strobe, go to IDLE, and issue no resp.
  - err stays set until reset. A late mem_resp in IDLE is ignored.
- mem_resp and the timeout in the same cycle: mem_resp wins and err is not set.
- Reset mid-transaction: rst==0 in any state forces the reset values on the next edge. The outstanding transaction is abandoned and no resp is issued.
- The arbiter never asserts mem_read and mem_write together.

Decomposition:
- Shared package cache_arb_types:
  - Enum arb_state_t {IDLE, I_MEM, D_RD, D_WR, RESP}.
  - Enum requester_t {ICACHE, DCACHE}.
  - Line and address width localparams, shared with the caches and the cacheline adaptor.
- One natural sub-module: arb_watchdog, the parameterised timeout counter with start, clear and expire. All other logic stays in cache_mem_arbiter.

Test Plan:
- Single ifetch: i_read, i_address=0x0000_0064 at cycle 0 → mem_read=1 and mem_address=0x0000_0060 from cycle 1. mem_resp at cycle 10 with rdata=0xA5…A5 → i_resp pulse at cycle 11, i_rdata=0xA5…A5, d_resp=0, mem_read=0 at cycle 11.
- Tie after reset: i_read and d_read both high at cycle 0 → dcache granted first (last_grant=ICACHE). After d_resp, the held i_read is granted next; with ROUND_ROBIN=0 the dcache wins every tie.
- Writeback data latch: d_write, d_address=0x8000_0040, d_wdata=0x1111… at grant; d_wdata changes to 0x2222… one cycle later → mem_write=1 with mem_wdata=0x1111… until mem_resp; d_resp pulses, d_rdata unchanged.
- Read/write conflict: d_read=d_write=1 → only mem_write asserts; mem_read stays 0 throughout.
- Timeout with TIMEOUT_CYCLES=16: i_read granted and mem_resp never arrives → err=1 and mem_read=0 after 16 cycles in I_MEM, no i_resp. A later mem_resp pulse is ignored and err stays 1.
- Reset mid-operation: rst=0 during D_RD before mem_resp → next cycle all outputs are at reset values, state is IDLE, no d_resp. A fresh i_read after rst=1 completes normally.
